cv32e40p_obi_instr_responder: RTL and testbench

OBI instruction-side responder: the memory end of the instruction fetch interface driven by the prefetcher's bus adapter. It accepts address-phase requests (req/gnt), reads a synchronous single-port word memory with 1-cycle read latency, and returns in-order responses (rvalid/rdata) after a fixed, parameterised latency. It enforces an outstanding-transaction limit and honours a memory-side stall. Used as the instruction memory front end in core testbench and FPGA top-levels.

---
 rtl/cv32e40p_obi_instr_responder.sv | 66 ++++++
 tb/tb_cv32e40p_obi_instr_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_instr_responder.sv
// cv32e40p_obi_instr_responder: OBI instruction memory responder; define CV32E40P_OBI_RESP_ERR_EN for out-of-range error responses
module cv32e40p_obi_instr_responder #(
    parameter int          RESP_LATENCY    = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          MEM_ADDR_WIDTH  = 14,
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,
    output logic                      mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]               mem_rdata_i,
    input  logic                      mem_stall_i
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1) + 1;
    logic [CW-1:0] cnt_q;
    logic [RESP_LATENCY-1:0] v_q;
    logic [31:0] off, raw;
    logic in_range, unused_addr;
    assign off = instr_addr_i - ADDR_BASE;
    assign unused_addr = ^off;
`ifdef CV32E40P_OBI_RESP_ERR_EN
    logic [RESP_LATENCY-1:0] e_q;
    assign in_range = (off >> (MEM_ADDR_WIDTH + 2)) == 32'd0;
    assign instr_err_o = e_q[RESP_LATENCY-1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) e_q <= '0;
        else e_q <= (e_q << 1) | RESP_LATENCY'(instr_gnt_o && !in_range);
`else
    assign in_range = 1'b1;
    assign instr_err_o = 1'b0;
`endif
    // a response retiring this cycle frees its slot for a same-cycle grant
    assign instr_gnt_o = instr_req_i && !mem_stall_i &&
                         ((cnt_q - CW'(instr_rvalid_o)) < CW'(MAX_OUTSTANDING));
    assign mem_req_o = instr_gnt_o && in_range;
    assign mem_addr_o = off[MEM_ADDR_WIDTH+1:2];
    assign instr_rvalid_o = v_q[RESP_LATENCY-1];
    assign instr_rdata_o = (instr_rvalid_o && !instr_err_o) ? raw : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q <= '0;
            v_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(instr_gnt_o) - CW'(instr_rvalid_o);
            v_q <= (v_q << 1) | RESP_LATENCY'(instr_gnt_o);
        end
    if (RESP_LATENCY == 1) begin : g_pass
        assign raw = mem_rdata_i;
    end else begin : g_pipe
        logic [RESP_LATENCY-2:0][31:0] d_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) d_q <= '0;
            else begin
                d_q[0] <= mem_rdata_i;
                for (int i = 1; i < RESP_LATENCY - 1; i++) d_q[i] <= d_q[i-1];
            end
        assign raw = d_q[RESP_LATENCY-2];
    end
endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// tb_cv32e40p_obi_instr_responder: queue-based response model across three latency/outstanding configurations
module tb_cv32e40p_obi_instr_responder;
    typedef struct {int due; logic [31:0] d; logic e;} rsp_t;
    logic clk = 0, rst_n, req, stall;
    logic [31:0] addr;
    int cyc = 0, checks = 0, failures = 0, b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memval(input logic [13:0] i);
        return i == 14'h10 ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {18'd0, i});
    endfunction

    function automatic logic [15:0] win(input logic [511:0] v, input int s);
        return 16'(v >> s);
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", nm, g, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_i
        localparam int L = g == 0 ? 2 : g == 1 ? 4 : 1;
        localparam int M = g == 2 ? 1 : 2;
        localparam logic [31:0] B = g == 1 ? 32'h100 : 32'h0;
        logic gnt, rvalid, err, mreq, rd_v;
        logic [31:0] rdata, mrdata;
        logic [13:0] maddr, rd_q;
        logic [511:0] gl = '0, rl = '0;
        rsp_t q[$];

        cv32e40p_obi_instr_responder #(
            .RESP_LATENCY(L), .MAX_OUTSTANDING(M), .MEM_ADDR_WIDTH(14), .ADDR_BASE(B)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .instr_req_i(req), .instr_gnt_o(gnt), .instr_addr_i(addr),
            .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err),
            .mem_req_o(mreq), .mem_addr_o(maddr), .mem_rdata_i(mrdata), .mem_stall_i(stall)
        );

        // backing memory: data for a read shows up the cycle after the strobe, junk otherwise
        always @(posedge clk) begin
            rd_v <= mreq;
            rd_q <= maddr;
        end
        assign mrdata = rd_v ? memval(rd_q) : {16'hBAD0, cyc[15:0]};

        always @(negedge clk) begin
            int hv;
            logic eg, inr, ee;
            logic [31:0] off, ed;
            rsp_t r;
            gl[cyc] = gnt;
            rl[cyc] = rvalid;
            if (!rst_n) begin
                q.delete();
                chk("rst_rvalid", g, rvalid, 0);
                chk("rst_cnt", g, u_dut.cnt_q, 0);
            end else begin
                off = addr - B;
`ifdef CV32E40P_OBI_RESP_ERR_EN
                inr = off < 32'h0001_0000;
`else
                inr = 1'b1;
`endif
                hv = (q.size() > 0 && q[0].due == cyc) ? 1 : 0;
                eg = req && !stall && (q.size() - hv) < M;
                ed = 0;
                ee = 0;
                if (hv != 0) begin
                    ed = q[0].d;
                    ee = q[0].e;
                end
                chk("gnt", g, gnt, eg);
                chk("rvalid", g, rvalid, hv != 0);
                chk("rdata", g, rdata, ed);
                chk("err", g, err, ee);
                chk("mem_req", g, mreq, eg && inr);
                if (eg && inr) chk("mem_addr", g, maddr, off[15:2]);
                chk("cnt", g, u_dut.cnt_q, q.size());
                chk("cnt_max", g, u_dut.cnt_q <= M, 1);
                if (hv != 0) void'(q.pop_front());
                if (eg) begin
                    r.due = cyc + L;
                    r.d = inr ? memval(off[15:2]) : 32'd0;
                    r.e = !inr;
                    q.push_back(r);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic [31:0] a, input logic s);
        req = r;
        addr = a;
        stall = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 0;
        stall = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 0; req = 0; stall = 0; addr = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(2);

        // single fetch of 0xDEADBEEF at word 0x10
        b = cyc; req = 1; addr = 32'h40;
        @(negedge clk);
        chk("sf_gnt", 0, g_i[0].gnt, 1);
        chk("sf_mreq", 0, g_i[0].mreq, 1);
        chk("sf_maddr", 0, g_i[0].maddr, 14'h10);
        @(posedge clk);
        #1 req = 0;
        at(b + 2);
        chk("sf_rdata", 0, g_i[0].rdata, 32'hDEAD_BEEF);
        idle(4);
        chk("sf_gwin", 0, win(g_i[0].gl, b) & 16'h3F, 16'h01);
        chk("sf_rwin", 0, win(g_i[0].rl, b) & 16'h3F, 16'h04);

        // streaming 0x0..0xC
        b = cyc;
        for (int i = 0; i < 4; i++) drive(1, 32'(4 * i), 0);
        idle(12);
        chk("st_gwin", 0, win(g_i[0].gl, b) & 16'hF, 16'hF);
        chk("st_rwin", 0, win(g_i[0].rl, b) & 16'h3F, 16'h3C);
        chk("st_gwin", 2, win(g_i[2].gl, b) & 16'hF, 16'hF);
        chk("st_rwin", 2, win(g_i[2].rl, b) & 16'h3F, 16'h1E);

        // throttle against MAX_OUTSTANDING=2, RESP_LATENCY=4
        b = cyc;
        repeat (6) drive(1, 32'h100, 0);
        idle(12);
        chk("th_gwin", 1, win(g_i[1].gl, b) & 16'hFFF, 16'h033);
        chk("th_rwin", 1, win(g_i[1].rl, b) & 16'hFFF, 16'h330);

        // memory stall in cycles 1..3
        b = cyc;
        drive(1, 32'h44, 0);
        repeat (3) drive(1, 32'h44, 1);
        drive(1, 32'h44, 0);
        idle(10);
        chk("sl_gwin", 0, win(g_i[0].gl, b) & 16'hFF, 16'h11);
        chk("sl_rwin", 0, win(g_i[0].rl, b) & 16'hFF, 16'h44);

        // reset one cycle after two grants
        b = cyc;
        drive(1, 32'h8, 0);
        drive(1, 32'hC, 0);
        req = 0;
        rst_n = 0;
        at(b + 3);
        chk("rs_rvalid", 0, g_i[0].rvalid, 0);
        chk("rs_cnt", 0, g_i[0].u_dut.cnt_q, 0);
        @(posedge clk);
        #1 rst_n = 1;
        idle(10);
        chk("rs_gwin", 0, win(g_i[0].gl, b) & 16'hFFF, 16'h003);
        chk("rs_rwin", 0, win(g_i[0].rl, b) & 16'hFFF, 16'h000);

        // address just past the 64 KiB memory
        b = cyc; req = 1; addr = 32'h0001_0040;
        @(negedge clk);
        chk("oor_gnt", 0, g_i[0].gnt, 1);
`ifdef CV32E40P_OBI_RESP_ERR_EN
        chk("oor_mreq", 0, g_i[0].mreq, 0);
`else
        chk("oor_mreq", 0, g_i[0].mreq, 1);
        chk("oor_maddr", 0, g_i[0].maddr, 14'h10);
`endif
        @(posedge clk);
        #1 req = 0;
        at(b + 2);
        chk("oor_rvalid", 0, g_i[0].rvalid, 1);
`ifdef CV32E40P_OBI_RESP_ERR_EN
        chk("oor_err", 0, g_i[0].err, 1);
        chk("oor_rdata", 0, g_i[0].rdata, 32'h0);
`else
        chk("oor_err", 0, g_i[0].err, 0);
        chk("oor_rdata", 0, g_i[0].rdata, 32'hDEAD_BEEF);
`endif
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
